cv32e40p_fetch_aligner: RTL

//  Sits between the prefetch buffer and the compressed decoder in the IF stage.

---
 rtl/cv32e40p_fetch_aligner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cv32e40p_fetch_aligner.sv
// IF-stage aligner: turns word-aligned fetch words into one instruction per
// cycle, rebuilding 32-bit instructions split across words; owns the IF pc.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   fetch_valid_i     fetch_rdata_i holds a valid word
//   fetch_rdata_i     word-aligned fetch word
//   aligner_ready_o   fetch word consumed if fetch_valid_i & if_valid_i
//   if_valid_i        IF hands the current instruction to ID
//   branch_i          redirect to branch_addr_i, flushes state
//   branch_addr_i     redirect target
//   hwlp_update_pc_i  next instruction is at hwlp_addr_i
//   hwlp_addr_i       hardware-loop start address
//   instr_aligned_o   instruction at pc_o
//   instr_valid_o     instr_aligned_o is usable
//   pc_o              address of instr_aligned_o
module cv32e40p_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        aligner_ready_o,
  input  logic        if_valid_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_update_pc_i,
  input  logic [31:0] hwlp_addr_i,
  output logic [31:0] instr_aligned_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    ALIGNED,
    MIS32,
    MIS16,
    BRMIS
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;

  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic        take;
  logic        up32;

  // Upper halfword of the current word starts a 32-bit instruction.
  assign up32 = (fetch_rdata_i[17:16] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIGNED;
      pc_q    <= RESET_PC;
      hold_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    instr = fetch_rdata_i;
    valid = 1'b0;
    ready = 1'b1;
    unique case (state_q)
      ALIGNED: begin
        instr = fetch_rdata_i;
        valid = fetch_valid_i;
      end
      MIS32: begin
        instr = {fetch_rdata_i[15:0], hold_q};
        valid = fetch_valid_i;
      end
      MIS16: begin
        instr = {16'h0, hold_q};
        valid = 1'b1;
        ready = 1'b0;
      end
      BRMIS: begin
        instr = {16'h0, fetch_rdata_i[31:16]};
        valid = fetch_valid_i & ~up32;
      end
    endcase
  end

  assign take = if_valid_i & valid & ~branch_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    if (branch_i) begin
      pc_d    = branch_addr_i;
      hold_d  = 16'h0;
      state_d = branch_addr_i[1] ? BRMIS : ALIGNED;
    end else if (take && hwlp_update_pc_i) begin
      pc_d    = hwlp_addr_i;
      hold_d  = 16'h0;
      state_d = hwlp_addr_i[1] ? BRMIS : ALIGNED;
    end else if (take) begin
      unique case (state_q)
        ALIGNED: begin
          if (fetch_rdata_i[1:0] == 2'b11) begin
            pc_d = pc_q + 32'd4;
          end else begin
            pc_d    = pc_q + 32'd2;
            hold_d  = fetch_rdata_i[31:16];
            state_d = up32 ? MIS32 : MIS16;
          end
        end
        MIS32: begin
          pc_d    = pc_q + 32'd4;
          hold_d  = fetch_rdata_i[31:16];
          state_d = up32 ? MIS32 : MIS16;
        end
        MIS16: begin
          pc_d    = pc_q + 32'd2;
          state_d = ALIGNED;
        end
        BRMIS: begin
          pc_d    = pc_q + 32'd2;
          state_d = ALIGNED;
        end
      endcase
    end else if (state_q == BRMIS && fetch_valid_i && up32) begin
      // Target's upper half opens a 32-bit instruction: park it, pc stays.
      hold_d  = fetch_rdata_i[31:16];
      state_d = MIS32;
    end
  end

  assign instr_aligned_o = instr;
  assign instr_valid_o   = valid & ~branch_i;
  assign aligner_ready_o = ready & ~branch_i;
  assign pc_o            = pc_q;

endmodule
